// File: rtl/interval_classifier.sv
// Two-stage pipelined classifier of fpnew-format scalars into programmable bins, with saturating per-bin hit counters.
// Latency 2 cycles, 1 sample/cycle; in_ready_o depends only on pipeline state and out_ready_i, never on in_valid_i.

package fpnew_pkg;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction
endpackage

module interval_classifier #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP8,
  parameter int unsigned NumIntervals = 8,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned WIDTH = fpnew_pkg::fp_width(FpFormat),
  localparam int unsigned IdxWidth = $clog2(NumIntervals)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WIDTH-1:0]        s_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NumIntervals-1:0] interval_o,
  output logic [IdxWidth-1:0]     index_o,
  output logic                    nan_o,
  input  logic                    bnd_we_i,
  input  logic [IdxWidth-1:0]     bnd_addr_i,
  input  logic [WIDTH-1:0]        bnd_data_i,
  output logic                    order_err_o,
  input  logic [IdxWidth-1:0]     cnt_addr_i,
  output logic [CntWidth-1:0]     cnt_o,
  input  logic                    cnt_clr_i
);

  localparam int unsigned ExpBits = fpnew_pkg::exp_bits(FpFormat);
  localparam int unsigned ManBits = fpnew_pkg::man_bits(FpFormat);
  localparam int unsigned NumBnd  = NumIntervals - 1;

  function automatic logic is_nan(logic [WIDTH-1:0] v);
    return (&v[WIDTH-2 -: ExpBits]) && (|v[ManBits-1:0]);
  endfunction

  // Signed ordering key: negating the magnitude makes -0 and +0 both map to 0.
  function automatic logic signed [WIDTH:0] ord_key(logic [WIDTH-1:0] v);
    logic signed [WIDTH:0] mag;
    mag = {2'b00, v[WIDTH-2:0]};
    return v[WIDTH-1] ? -mag : mag;
  endfunction

  function automatic logic fp_ge(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return !is_nan(a) && !is_nan(b) && (ord_key(a) >= ord_key(b));
  endfunction

  logic [WIDTH-1:0]        bnd_q [NumBnd];
  logic                    s1_vld_q;
  logic [WIDTH-1:0]        s1_s_q;
  logic [NumBnd-1:0]       s1_cmp_q;
  logic [NumBnd-1:0]       cmp_d;
  logic                    s2_vld_q;
  logic [NumIntervals-1:0] onehot_q, onehot_d;
  logic [IdxWidth-1:0]     idx_q, idx_d;
  logic                    nan_q, nan_d;
  logic [CntWidth-1:0]     cnt_q [NumIntervals];
  logic                    s1_adv, s2_fire, accept;

  assign s2_fire    = s2_vld_q & out_ready_i;
  assign s1_adv     = s1_vld_q & (!s2_vld_q | s2_fire);
  assign in_ready_o = !s1_vld_q | s1_adv;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    cmp_d = '0;
    for (int i = 0; i < int'(NumBnd); i++) begin
      cmp_d[i] = fp_ge(s_i, bnd_q[i]);
    end
  end

  always_comb begin
    idx_d = '0;
    for (int i = 0; i < int'(NumBnd); i++) begin
      idx_d = idx_d + IdxWidth'(s1_cmp_q[i]);
    end
    nan_d = is_nan(s1_s_q);
    if (nan_d) idx_d = '0;
    onehot_d = '0;
    for (int k = 0; k < int'(NumIntervals); k++) begin
      onehot_d[k] = !nan_d && (idx_d == IdxWidth'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumBnd); i++) bnd_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NumBnd); i++) begin
        if (bnd_we_i && bnd_addr_i == IdxWidth'(i)) bnd_q[i] <= bnd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_s_q   <= '0;
      s1_cmp_q <= '0;
    end else if (in_ready_o) begin
      s1_vld_q <= in_valid_i;
      if (accept) begin
        s1_s_q   <= s_i;
        s1_cmp_q <= cmp_d;
      end
    end
  end

  // Payload only changes on a load, so a stalled or drained result holds still.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld_q <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      nan_q    <= 1'b0;
    end else if (!s2_vld_q || s2_fire) begin
      s2_vld_q <= s1_adv;
      if (s1_adv) begin
        onehot_q <= onehot_d;
        idx_q    <= idx_d;
        nan_q    <= nan_d;
      end
    end
  end

  assign out_valid_o = s2_vld_q;
  assign interval_o  = onehot_q;
  assign index_o     = idx_q;
  assign nan_o       = nan_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NumIntervals); k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NumIntervals); k++) begin
        if (cnt_clr_i) begin
          cnt_q[k] <= '0;
        end else if (s2_fire && !nan_q && idx_q == IdxWidth'(k) && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < int'(NumIntervals); k++) begin
      if (cnt_addr_i == IdxWidth'(k)) cnt_o = cnt_q[k];
    end
  end

  // NaN boundaries fail the compare and are therefore reported as disordered.
  always_comb begin
    order_err_o = 1'b0;
    for (int i = 0; i + 1 < int'(NumBnd); i++) begin
      if (!fp_ge(bnd_q[i+1], bnd_q[i])) order_err_o = 1'b1;
    end
  end

endmodule
